// File: rtl/wmem_pkg.sv
// Shared defaults and helpers for the hidden-layer weight memory.
// Optional same-cycle read forwarding is enabled by defining WMEM_RD_FWD_EN.
package wmem_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_N_IN     = 8;
   localparam int DEF_N_HIDDEN = 4;

   // Address width for n entries, never narrower than one bit.
   function automatic int clog2_min2(input int n);
      int v;
      v = (n < 2) ? 2 : n;
      return $clog2(v);
   endfunction

   function automatic int flat_addr(input int h, input int i, input int n_in);
      return h * n_in + i;
   endfunction

endpackage

// File: rtl/wmem_wr_stage.sv
// Write staging register: range-checks the (row, column) write request
// and holds the flattened address and data for the following commit edge.
module wmem_wr_stage
   import wmem_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int N_IN     = DEF_N_IN,
   parameter int N_HIDDEN = DEF_N_HIDDEN,
   parameter int ADDR_H_W = clog2_min2(N_HIDDEN),
   parameter int ADDR_I_W = clog2_min2(N_IN),
   parameter int RADDR_W  = clog2_min2(N_HIDDEN * N_IN)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en_i,
   input  logic [ADDR_H_W-1:0]       addr_h_i,
   input  logic [ADDR_I_W-1:0]       addr_i_i,
   input  logic signed [DATA_W-1:0]  data_i,
   output logic                      st_valid_o,
   output logic [RADDR_W-1:0]        st_addr_o,
   output logic signed [DATA_W-1:0]  st_data_o
);

   logic                      in_range;
   logic                      valid_d, valid_q;
   logic [RADDR_W-1:0]        addr_d, addr_q;
   logic signed [DATA_W-1:0]  data_d, data_q;

   assign in_range = (int'(addr_h_i) < N_HIDDEN) && (int'(addr_i_i) < N_IN);

   // Out-of-range requests never become valid, so memory is left untouched.
   always_comb begin
      valid_d = wr_en_i && in_range;
      addr_d  = RADDR_W'(flat_addr(int'(addr_h_i), int'(addr_i_i), N_IN));
      data_d  = data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign st_valid_o = valid_q;
   assign st_addr_o  = addr_q;
   assign st_data_o  = data_q;

endmodule

// File: rtl/wmem_hidden.sv
// Hidden-layer weight memory: two-stage write pipeline, registered read port.
// Define WMEM_RD_FWD_EN to return staged data on a same-cycle read/commit hit.
module wmem_hidden
   import wmem_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int N_IN     = DEF_N_IN,
   parameter int N_HIDDEN = DEF_N_HIDDEN,
   localparam int WMEM_SIZE = N_HIDDEN * N_IN,
   localparam int ADDR_H_W  = clog2_min2(N_HIDDEN),
   localparam int ADDR_I_W  = clog2_min2(N_IN),
   localparam int RADDR_W   = clog2_min2(WMEM_SIZE)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      w_wr_en,
   input  logic [ADDR_H_W-1:0]       w_addr_h,
   input  logic [ADDR_I_W-1:0]       w_addr_i,
   input  logic signed [DATA_W-1:0]  w_data,
   input  logic [RADDR_W-1:0]        raddr,
   output logic signed [DATA_W-1:0]  rdata
);

   logic                      st_valid;
   logic [RADDR_W-1:0]        st_addr;
   logic signed [DATA_W-1:0]  st_data;
   logic signed [DATA_W-1:0]  mem_q [WMEM_SIZE];
   logic signed [DATA_W-1:0]  rdata_d, rdata_q;

   wmem_wr_stage #(
      .DATA_W   (DATA_W),
      .N_IN     (N_IN),
      .N_HIDDEN (N_HIDDEN),
      .ADDR_H_W (ADDR_H_W),
      .ADDR_I_W (ADDR_I_W),
      .RADDR_W  (RADDR_W)
   ) u_wr_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (w_wr_en),
      .addr_h_i   (w_addr_h),
      .addr_i_i   (w_addr_i),
      .data_i     (w_data),
      .st_valid_o (st_valid),
      .st_addr_o  (st_addr),
      .st_data_o  (st_data)
   );

   always_comb begin
      rdata_d = '0;
      if (int'(raddr) < WMEM_SIZE) begin
         rdata_d = mem_q[raddr];
      end
`ifdef WMEM_RD_FWD_EN
      if (st_valid && (st_addr == raddr)) begin
         rdata_d = st_data;
      end
`endif
   end

   // Flop-based storage so the whole array clears on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WMEM_SIZE; k++) begin
            mem_q[k] <= '0;
         end
         rdata_q <= '0;
      end else begin
         if (st_valid) begin
            mem_q[st_addr] <= st_data;
         end
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_wmem_hidden.sv
// Directed bench for wmem_hidden at default parameters (16-bit, 4x8 words).
module tb_wmem_hidden;

   logic               clk;
   logic               rst_n;
   logic               w_wr_en;
   logic [1:0]         w_addr_h;
   logic [2:0]         w_addr_i;
   logic signed [15:0] w_data;
   logic [4:0]         raddr;
   logic signed [15:0] rdata;

   logic signed [15:0] exp_mem [32];
   logic [15:0]        exp_q [$];
   int                 checks;
   int                 errors;

   wmem_hidden dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_wr_en  (w_wr_en),
      .w_addr_h (w_addr_h),
      .w_addr_i (w_addr_i),
      .w_data   (w_data),
      .raddr    (raddr),
      .rdata    (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One write transaction: sampled at the posedge following the first negedge.
   task automatic drive_write(input int h, input int i, input int v);
      @(negedge clk);
      w_wr_en  = 1'b1;
      w_addr_h = 2'(h);
      w_addr_i = 3'(i);
      w_data   = 16'(v);
      @(negedge clk);
      w_wr_en  = 1'b0;
      exp_mem[h * 8 + i] = 16'(v);
   endtask

   task automatic read_addr(input int a, output logic signed [15:0] v);
      @(negedge clk);
      raddr = 5'(a);
      @(posedge clk);
      #1;
      v = rdata;
   endtask

   task automatic test_reset();
      logic signed [15:0] v;
      rst_n = 1'b0; w_wr_en = 1'b0; w_addr_h = '0; w_addr_i = '0;
      w_data = '0; raddr = '0;
      for (int k = 0; k < 32; k++) exp_mem[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rdata !== 16'sd0) begin
         errors++;
         $display("FAIL reset_rdata_low: got %0d expected 0", rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         read_addr(a, v);
         checks++;
         if (v !== 16'sd0) begin
            errors++;
            $display("FAIL reset_read addr=%0d: got %0d expected 0", a, v);
         end
      end
   endtask

   task automatic test_seq_load();
      logic signed [15:0] v;
      for (int h = 0; h < 4; h++)
         for (int i = 0; i < 8; i++)
            drive_write(h, i, h * 10 + i + 1);
      read_addr(19, v);
      checks++;
      if (v !== 16'sd24) begin
         errors++;
         $display("FAIL seq_addr19: got %0d expected 24", v);
      end
      for (int a = 0; a < 32; a++) begin
         read_addr(a, v);
         checks++;
         if (v !== exp_mem[a]) begin
            errors++;
            $display("FAIL seq_read addr=%0d: got %0d expected %0d", a, v, exp_mem[a]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic signed [15:0] v;
      @(negedge clk);
      w_wr_en = 1'b1; w_addr_h = 2'd0; w_addr_i = 3'd0; w_data = 16'sd100;
      @(negedge clk);
      w_data = 16'sd200;
      @(negedge clk);
      w_data = 16'sd300;
      @(negedge clk);
      w_wr_en = 1'b0;
      exp_mem[0] = 16'sd300;
      read_addr(0, v);
      checks++;
      if (v !== 16'sd300) begin
         errors++;
         $display("FAIL overwrite_addr0: got %0d expected 300", v);
      end
      read_addr(1, v);
      checks++;
      if (v !== exp_mem[1]) begin
         errors++;
         $display("FAIL overwrite_neighbor: got %0d expected %0d", v, exp_mem[1]);
      end
   endtask

   task automatic test_concurrent();
      logic signed [15:0] v;
      logic signed [15:0] exp18;
      exp18 = exp_mem[18];
      @(negedge clk);
      w_wr_en = 1'b1; w_addr_h = 2'd1; w_addr_i = 3'd1; w_data = 16'sd111;
      raddr = 5'd18;
      @(negedge clk);
      w_wr_en = 1'b0;
      exp_mem[9] = 16'sd111;
      // Next posedge commits addr 9 while addr 18 is being read.
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== exp18) begin
         errors++;
         $display("FAIL concurrent_addr18: got %0d expected %0d", rdata, exp18);
      end
      read_addr(9, v);
      checks++;
      if (v !== 16'sd111) begin
         errors++;
         $display("FAIL concurrent_addr9: got %0d expected 111", v);
      end
   endtask

   task automatic test_negative_random();
      logic signed [15:0] v;
      int h, i, val;
      drive_write(3, 7, -500);
      read_addr(31, v);
      checks++;
      if (v !== 16'hFE0C) begin
         errors++;
         $display("FAIL negative_addr31: got %h expected fe0c", v);
      end
      for (int n = 0; n < 15; n++) begin
         h   = $urandom_range(0, 3);
         i   = $urandom_range(0, 7);
         val = int'($urandom_range(0, 1000)) - 500;
         drive_write(h, i, val);
         exp_q.push_back(exp_mem[h * 8 + i]);
         read_addr(h * 8 + i, v);
         checks++;
         if (v !== exp_q[0]) begin
            errors++;
            $display("FAIL random_pair %0d addr=%0d: got %0d expected %0d",
                     n, h * 8 + i, v, $signed(exp_q[0]));
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_same_cycle();
      logic signed [15:0] v;
      logic signed [15:0] exp_hit;
`ifdef WMEM_RD_FWD_EN
      exp_hit = 16'sd77;
`else
      exp_hit = exp_mem[9];
`endif
      @(negedge clk);
      w_wr_en = 1'b1; w_addr_h = 2'd1; w_addr_i = 3'd1; w_data = 16'sd77;
      @(negedge clk);
      w_wr_en = 1'b0;
      raddr   = 5'd9;
      exp_mem[9] = 16'sd77;
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== exp_hit) begin
         errors++;
         $display("FAIL same_cycle_hit: got %0d expected %0d", rdata, exp_hit);
      end
      read_addr(9, v);
      checks++;
      if (v !== 16'sd77) begin
         errors++;
         $display("FAIL same_cycle_after: got %0d expected 77", v);
      end
   endtask

   task automatic test_reset_mid_write();
      logic signed [15:0] v;
      @(negedge clk);
      w_wr_en = 1'b1; w_addr_h = 2'd2; w_addr_i = 3'd5; w_data = 16'sd999;
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      w_wr_en = 1'b0;
      #1;
      checks++;
      if (rdata !== 16'sd0) begin
         errors++;
         $display("FAIL midreset_rdata_low: got %0d expected 0", rdata);
      end
      for (int k = 0; k < 32; k++) exp_mem[k] = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         read_addr(a, v);
         checks++;
         if (v !== 16'sd0) begin
            errors++;
            $display("FAIL midreset_read addr=%0d: got %0d expected 0", a, v);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_seq_load();
      test_back_to_back();
      test_concurrent();
      test_negative_random();
      test_same_cycle();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
